// File: rtl/jump_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// jump_ctrl_pkg
// Shared constants and types for the jump/branch controller:
//   - 6-bit jump opcodes decoded in the fetch stage
//   - FSM state encoding for interrupt vectoring
//   - default interrupt vector table base and stride
// ----------------------------------------------------------------------------
package jump_ctrl_pkg;

    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_RET = 6'b010000;
    localparam logic [5:0] OP_JV  = 6'b011100;
    localparam logic [5:0] OP_JNV = 6'b011101;
    localparam logic [5:0] OP_JZ  = 6'b011110;
    localparam logic [5:0] OP_JNZ = 6'b011111;

    localparam logic [15:0] VEC_BASE_DEF   = 16'hF000;
    localparam logic [15:0] VEC_STRIDE_DEF = 16'h0010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VECTOR = 2'd1,
        SAVE   = 2'd2
    } state_t;

endpackage

// File: rtl/jc_ret_stack.sv
// ----------------------------------------------------------------------------
// jc_ret_stack
// LIFO of interrupt return contexts (return address + saved flags).
// A push stores the address with cleared flags; the flags of the top entry
// are filled in later through the flag-write port.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset (clears the count)
//   i_push            push i_push_addr (ignored when full)
//   i_push_addr       return address to save
//   i_pop             drop the top entry (ignored when empty)
//   i_wr_flag         overwrite the flags of the top entry with i_flag
//   i_flag            flags to store
//   o_top_addr        address of the top entry
//   o_top_flags       flags of the top entry
//   o_count           number of valid entries
//   o_full, o_empty   count == STACK_DEPTH / count == 0
// ----------------------------------------------------------------------------
module jc_ret_stack #(
    parameter int ADDR_W      = 16,
    parameter int FLAG_W      = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_push,
    input  logic [ADDR_W-1:0]                  i_push_addr,
    input  logic                               i_pop,
    input  logic                               i_wr_flag,
    input  logic [FLAG_W-1:0]                  i_flag,
    output logic [ADDR_W-1:0]                  o_top_addr,
    output logic [FLAG_W-1:0]                  o_top_flags,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_count,
    output logic                               o_full,
    output logic                               o_empty
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int ENTRY_W = ADDR_W + FLAG_W;
    localparam logic [DEPTH_W-1:0] FULL_CNT = DEPTH_W'(STACK_DEPTH);

    logic [ENTRY_W-1:0] r_mem [STACK_DEPTH];
    logic [DEPTH_W-1:0] r_count;
    logic [IDX_W-1:0]   w_top_idx;
    logic [IDX_W-1:0]   w_push_idx;

    assign w_top_idx  = IDX_W'(r_count - 1'b1);
    assign w_push_idx = IDX_W'(r_count);
    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_top_addr  = r_mem[w_top_idx][ENTRY_W-1:FLAG_W];
    assign o_top_flags = r_mem[w_top_idx][FLAG_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; entries above r_count are never
    // read as valid, so clearing the count is enough to invalidate them.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_push_idx] <= {i_push_addr, {FLAG_W{1'b0}}};
        end else if (i_wr_flag && !i_pop && !o_empty) begin
            r_mem[w_top_idx][FLAG_W-1:0] <= i_flag;
        end
    end

endmodule

// File: rtl/jump_ctrl_nested.sv
// ----------------------------------------------------------------------------
// jump_ctrl_nested
// Jump/branch controller for the fetch stage with vectored, nestable
// interrupts. Decodes jump opcodes against execute-stage flags, selects the
// PC redirect target, and pushes/pops return contexts on an internal LIFO.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   jmp_address_pm    jump target from program memory
//   current_address   PC of the instruction in decode
//   op                opcode
//   flag_ex           execute-stage flags (bit0 = V, bit1 = Z)
//   irq, irq_mask     level-sensitive requests and enables (0 = highest prio)
//   jmp_loc           redirect target
//   pc_mux_sel        1 = PC takes jmp_loc
//   irq_ack           one-hot acknowledge in the vector cycle
//   flag_restore(_vld) flags returned by RET and their valid strobe
//   depth, stack_full current nesting depth and full indication
//   ret_err           RET issued with an empty stack
// ----------------------------------------------------------------------------
module jump_ctrl_nested
    import jump_ctrl_pkg::*;
#(
    parameter int                 ADDR_W      = 16,
    parameter int                 FLAG_W      = 2,
    parameter int                 NUM_IRQ     = 4,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  VEC_BASE    = ADDR_W'(VEC_BASE_DEF),
    parameter logic [ADDR_W-1:0]  VEC_STRIDE  = ADDR_W'(VEC_STRIDE_DEF)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 jmp_address_pm,
    input  logic [ADDR_W-1:0]                 current_address,
    input  logic [5:0]                        op,
    input  logic [FLAG_W-1:0]                 flag_ex,
    input  logic [NUM_IRQ-1:0]                irq,
    input  logic [NUM_IRQ-1:0]                irq_mask,
    output logic [ADDR_W-1:0]                 jmp_loc,
    output logic                              pc_mux_sel,
    output logic [NUM_IRQ-1:0]                irq_ack,
    output logic [FLAG_W-1:0]                 flag_restore,
    output logic                              flag_restore_vld,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  depth,
    output logic                              stack_full,
    output logic                              ret_err
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     w_id;
    logic [NUM_IRQ-1:0]  w_pend;
    logic                w_taken;
    logic                w_is_ret;
    logic [ADDR_W-1:0]   w_vec;
    logic [ADDR_W-1:0]   w_push_addr;
    logic                w_push;
    logic                w_pop;
    logic                w_wr_flag;
    logic [ADDR_W-1:0]   w_top_addr;
    logic [FLAG_W-1:0]   w_top_flags;
    logic                w_full;
    logic                w_empty;

    assign w_pend   = irq & irq_mask;
    assign w_is_ret = (op == OP_RET);
    // Vector address wraps modulo 2^ADDR_W.
    assign w_vec    = VEC_BASE + VEC_STRIDE * ADDR_W'(r_id);
    // A jump taken in the accept cycle becomes the return address.
    assign w_push_addr = w_taken ? jmp_address_pm : current_address + 1'b1;

    // Jump condition decode.
    always_comb begin
        unique case (op)
            OP_JMP:  w_taken = 1'b1;
            OP_JV:   w_taken = flag_ex[0];
            OP_JNV:  w_taken = !flag_ex[0];
            OP_JZ:   w_taken = flag_ex[1];
            OP_JNZ:  w_taken = !flag_ex[1];
            default: w_taken = 1'b0;
        endcase
    end

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        w_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_push) begin
                r_id <= w_id;
            end
        end
    end

    // NOTE: every signal driven here is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state     = r_state;
        jmp_loc          = '0;
        pc_mux_sel       = 1'b0;
        irq_ack          = '0;
        flag_restore     = '0;
        flag_restore_vld = 1'b0;
        ret_err          = 1'b0;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        w_wr_flag        = 1'b0;

        case (r_state)
            VECTOR: begin
                jmp_loc      = w_vec;
                pc_mux_sel   = 1'b1;
                // Suppressed under reset so an aborted interrupt never acks.
                irq_ack      = reset ? (NUM_IRQ'(1) << r_id) : '0;
                w_next_state = SAVE;
            end
            IDLE, SAVE: begin
                if (w_is_ret) begin
                    if (!w_empty) begin
                        jmp_loc          = w_top_addr;
                        pc_mux_sel       = 1'b1;
                        // In SAVE the top flags are not written yet; forward.
                        flag_restore     = (r_state == SAVE) ? flag_ex : w_top_flags;
                        flag_restore_vld = 1'b1;
                        w_pop            = 1'b1;
                    end else begin
                        ret_err = 1'b1;
                    end
                end else if (w_taken) begin
                    jmp_loc    = jmp_address_pm;
                    pc_mux_sel = 1'b1;
                end

                if (r_state == SAVE) begin
                    w_wr_flag    = !w_is_ret;
                    w_next_state = IDLE;
                end else if (!w_is_ret && (w_pend != '0) && !w_full) begin
                    w_push       = 1'b1;
                    w_next_state = VECTOR;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    jc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .FLAG_W      (FLAG_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_addr (w_push_addr),
        .i_pop       (w_pop),
        .i_wr_flag   (w_wr_flag),
        .i_flag      (flag_ex),
        .o_top_addr  (w_top_addr),
        .o_top_flags (w_top_flags),
        .o_count     (depth),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign stack_full = w_full;

endmodule
